// File: rtl/spram_pkg.sv
// Shared types and helpers for the banked SP256K controller.
//   - pwr_state_e     : per-bank power state (ACTIVE, SLEEP, WAKE)
//   - SPRAM_BANK_AW   : word address width of one 16K-word bank
//   - byte_to_maskwe  : maps two byte enables of a 16-bit half onto the
//                       4-bit nibble MASKWE of one SP256K
package spram_pkg;

  localparam int unsigned SPRAM_BANK_AW    = 14;
  localparam int unsigned SPRAM_BANK_WORDS = 1 << SPRAM_BANK_AW;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } pwr_state_e;

  // Byte b of a 16-bit half drives nibble bits {2b+1, 2b}.
  function automatic logic [3:0] byte_to_maskwe(input logic [1:0] byte_we);
    return {byte_we[1], byte_we[1], byte_we[0], byte_we[0]};
  endfunction

endpackage

// File: rtl/spram_bank_pwr.sv
// Idle-driven power manager for one SP256K bank.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_hit       : a request addresses this bank this cycle (accepted or not)
//   sleep         : registered SP256K SLEEP pin, high only in SLEEP
//   bank_sleep    : registered, high in SLEEP and WAKE
//   active_c      : combinational, bank may be accessed this cycle
module spram_bank_pwr
  import spram_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 1024,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_hit,
  output logic sleep,
  output logic bank_sleep,
  output logic active_c
);

  localparam int unsigned IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

  pwr_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WAKE_W-1:0] wake_q, wake_d;

  assign active_c = (state_q == ACTIVE);

  // Next-state: a request always beats an expiring idle counter.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ACTIVE: begin
        if (req_hit) begin
          idle_d = '0;
        end else if (IDLE_CYCLES != 0) begin
          if (idle_q == IDLE_W'(IDLE_CYCLES - 1)) begin
            state_d = SLEEP;
            idle_d  = IDLE_W'(IDLE_CYCLES);
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      SLEEP: begin
        if (req_hit) begin
          state_d = WAKE;
          wake_d  = WAKE_W'(WAKE_CYCLES);
        end
      end
      WAKE: begin
        // Leaving on the last count makes the bank ACTIVE WAKE_CYCLES+1
        // cycles after the waking request was first seen.
        if (wake_q <= WAKE_W'(1)) begin
          state_d = ACTIVE;
          idle_d  = '0;
          wake_d  = '0;
        end else begin
          wake_d = wake_q - WAKE_W'(1);
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  // State register; pin outputs follow the next state so they track it exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ACTIVE;
      idle_q     <= '0;
      wake_q     <= '0;
      sleep      <= 1'b0;
      bank_sleep <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      wake_q     <= wake_d;
      sleep      <= (state_d == SLEEP);
      bank_sleep <= (state_d != ACTIVE);
    end
  end

endmodule

// File: rtl/spram_banked_ctrl.sv
// Banked SP256K single-port RAM controller with request handshake,
// read-valid strobe and per-bank idle sleep.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_valid_i/ready_o : request handshake (ready is combinational)
//   addr_i              : word address, upper bits select the bank
//   wr_en_i, mask_we_i  : write strobe and byte enables
//   wr_data_i           : write data
//   rd_valid_o          : read data strobe
//   rd_data_o           : read data, zero when rd_valid_o is low
//   bank_sleep_o        : per bank, high while in SLEEP or WAKE
// Macro SPRAM_OUTREG_EN adds an output register after the bank mux
// (read latency 2 instead of 1).
// Each bank holds a behavioural SP256K equivalent (CS=1, STDBY=0,
// PWROFF_N=1; only WE, MASKWE and SLEEP are driven).
module spram_banked_ctrl
  import spram_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned IDLE_CYCLES = 1024,
  parameter int unsigned WAKE_CYCLES = 4,
  localparam int unsigned AW         = SPRAM_BANK_AW + $clog2(NUM_BANKS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AW-1:0]         addr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W/8-1:0]   mask_we_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  output logic                  rd_valid_o,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic [NUM_BANKS-1:0]  bank_sleep_o
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned HALVES = DATA_W / 16;

  logic [BANK_W-1:0]        bank_sel_c;
  logic [SPRAM_BANK_AW-1:0] word_addr_c;
  logic [NUM_BANKS-1:0]     bank_active_c;
  logic                     accept_c;
  logic                     rd_acc_c;
  logic [DATA_W-1:0]        wr_bitmask_c;
  logic [3:0]               nib_c;
  logic [DATA_W-1:0]        bank_dout [NUM_BANKS];
  logic [DATA_W-1:0]        rd_mux_c;
  logic                     rd_pipe_q;
  logic [BANK_W-1:0]        bank_q;

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign bank_sel_c = addr_i[AW-1:SPRAM_BANK_AW];
  end else begin : g_bank_sel_single
    assign bank_sel_c = '0;
  end

  assign word_addr_c = addr_i[SPRAM_BANK_AW-1:0];
  assign req_ready_o = bank_active_c[bank_sel_c] & ~rst_i;
  assign accept_c    = req_valid_i & req_ready_o;
  assign rd_acc_c    = accept_c & ~wr_en_i;

  // Expand byte enables to a per-bit mask through the nibble MASKWE mapping.
  always_comb begin
    wr_bitmask_c = '0;
    nib_c        = '0;
    for (int h = 0; h < int'(HALVES); h++) begin
      nib_c = byte_to_maskwe(mask_we_i[2*h +: 2]);
      for (int n = 0; n < 4; n++) begin
        wr_bitmask_c[16*h + 4*n +: 4] = {4{nib_c[n]}};
      end
    end
  end

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    logic              hit_c;
    logic              we_c;
    logic              sleep_pin;
    logic [DATA_W-1:0] mem [SPRAM_BANK_WORDS];
    logic [DATA_W-1:0] dout_q;

    assign hit_c = req_valid_i & (bank_sel_c == BANK_W'(b));
    assign we_c  = accept_c & wr_en_i & (bank_sel_c == BANK_W'(b));

    spram_bank_pwr #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_pwr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_hit    (hit_c),
      .sleep      (sleep_pin),
      .bank_sleep (bank_sleep_o[b]),
      .active_c   (bank_active_c[b])
    );

    // SP256K pair: masked write, or registered read of the presented address.
    always_ff @(posedge clk_i) begin
      if (we_c) begin
        mem[word_addr_c] <= (mem[word_addr_c] & ~wr_bitmask_c) | (wr_data_i & wr_bitmask_c);
      end else if (!sleep_pin) begin
        dout_q <= mem[word_addr_c];
      end
    end

    assign bank_dout[b] = dout_q;
  end

  // Read-valid pipeline; the bank index travels with the read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pipe_q <= 1'b0;
      bank_q    <= '0;
    end else begin
      rd_pipe_q <= rd_acc_c;
      if (rd_acc_c) begin
        bank_q <= bank_sel_c;
      end
    end
  end

  assign rd_mux_c = bank_dout[bank_q];

`ifdef SPRAM_OUTREG_EN
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_pipe_q;
      rd_data_q  <= rd_pipe_q ? rd_mux_c : '0;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
`else
  // Reset suppresses a read whose data would appear in the reset cycle.
  assign rd_valid_o = rd_pipe_q & ~rst_i;
  assign rd_data_o  = rd_valid_o ? rd_mux_c : '0;
`endif

endmodule

// File: tb/tb_spram_banked_ctrl.sv
// Testbench for spram_banked_ctrl: table-driven writes/reads with a
// scoreboard of expected read data and arrival cycle, plus hand-written
// sequences for sleep/wake, idle-expiry race and reset during a read.
module tb_spram_banked_ctrl;

`ifdef SPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [14:0] addr_i;
  logic        wr_en_i;
  logic [3:0]  mask_we_i;
  logic [31:0] wr_data_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic [1:0]  bank_sleep_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  spram_banked_ctrl #(
    .DATA_W      (32),
    .NUM_BANKS   (2),
    .IDLE_CYCLES (8),
    .WAKE_CYCLES (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .addr_i       (addr_i),
    .wr_en_i      (wr_en_i),
    .mask_we_i    (mask_we_i),
    .wr_data_i    (wr_data_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .bank_sleep_o (bank_sleep_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read monitor: every strobe must match the oldest expectation in data and cycle.
  always @(negedge clk_i) begin
    if (rd_valid_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got data %h with no read outstanding (cycle %0d)", rd_data_o, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rd_data", rd_data_o, e.data);
        chk("rd_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Present a request from the current cycle and hold it until accepted.
  task automatic issue(input logic wr, input logic [14:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [31:0] exp, output int waited);
    bit done;
    req_valid_i = 1'b1;
    wr_en_i     = wr;
    addr_i      = addr;
    mask_we_i   = mask;
    wr_data_i   = data;
    waited      = 0;
    done        = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        if (!wr) sbq.push_back('{exp, cyc + LAT});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 64) begin
          checks++;
          errors++;
          $display("FAIL req_timeout: addr %h not accepted after %0d cycles", addr, waited);
          done = 1'b1;
        end
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int w;
    int gaps;

    vecs[0] = '{1'b1, 15'h0003, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 15'h4003, 4'hF, 32'h12345678, 32'h0};
    vecs[2] = '{1'b0, 15'h0003, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 15'h4003, 4'h0, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 15'h0010, 4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[5] = '{1'b1, 15'h0010, 4'h5, 32'h00000000, 32'h0};
    vecs[6] = '{1'b0, 15'h0010, 4'h0, 32'h0,        32'hFF00FF00};
    vecs[7] = '{1'b1, 15'h4020, 4'hF, 32'h11111111, 32'h0};
    vecs[8] = '{1'b1, 15'h4020, 4'hA, 32'hAABBCCDD, 32'h0};
    vecs[9] = '{1'b0, 15'h4020, 4'h0, 32'h0,        32'hAA11CC11};

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    wr_en_i     = 1'b0;
    addr_i      = '0;
    mask_we_i   = '0;
    wr_data_i   = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_bank_sleep", 32'(bank_sleep_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1;

    // Table: bank separation and byte masks
    foreach (vecs[i]) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].exp, w);
    end

    // Streaming: 16 writes, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 15'(32'h100 + i), 4'hF, 32'hC0DE0000 | 32'(i), 32'h0, w);
    end
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 15'(32'h100 + i), 4'h0, 32'h0, 32'hC0DE0000 | 32'(i), w);
      if (i > 0) gaps += w;
    end
    chk("stream_stalls", 32'(gaps), 32'd0);

    // Both banks sleep after idling; wake penalty on bank 1
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("idle_sleep", 32'(bank_sleep_o), 32'b11);
    @(posedge clk_i);
    #1;
    issue(1'b0, 15'h4003, 4'h0, 32'h0, 32'h12345678, w);
    chk("wake_wait", 32'(w), 32'd5);
    @(negedge clk_i);
    chk("wake_sleep_bits", 32'(bank_sleep_o), 32'b01);
    @(posedge clk_i);
    #1;

    // Idle expiry and a request in the same cycle: request wins
    issue(1'b0, 15'h0003, 4'h0, 32'h0, 32'hDEADBEEF, w);
    repeat (7) @(posedge clk_i);
    #1;
    issue(1'b0, 15'h0010, 4'h0, 32'h0, 32'hFF00FF00, w);
    chk("race_wait", 32'(w), 32'd0);
    @(negedge clk_i);
    chk("race_sleep_bits", 32'(bank_sleep_o), 32'b10);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("race_bank0_awake", 32'(bank_sleep_o[0]), 32'd0);

    // Reset the cycle after a read accept: the read is dropped
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1;
    wr_en_i     = 1'b0;
    addr_i      = 15'h0003;
    @(negedge clk_i);
    chk("rst_read_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    rst_i       = 1'b1;
    @(negedge clk_i);
    chk("rst_drop_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_drop_data", rd_data_o, 32'd0);
    chk("rst_drop_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_drop_valid2", 32'(rd_valid_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_all_active", 32'(bank_sleep_o), 32'b00);
    chk("rst_ready_back", 32'(req_ready_o), 32'd1);

    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
